// File: rtl/i2c_slave_if.sv
// i2c_slave_if
//   I2C pin bundle between a bus model (or pad logic) and the i2c_slave target.
//   scl_in / sda_in     : bus levels as seen at the pins (asynchronous)
//   sda_out             : level driven on SDA while sda_out_mode is 1
//   sda_out_mode        : 1 = target drives SDA, 0 = target releases SDA
interface i2c_slave_if;
   logic scl_in;
   logic sda_in;
   logic sda_out;
   logic sda_out_mode;

   modport slave  (input  scl_in, sda_in, output sda_out, sda_out_mode);
   modport master (output scl_in, sda_in, input  sda_out, sda_out_mode);
endinterface

// File: rtl/i2c_slave.sv
// i2c_slave
//   Register-oriented I2C target. Oversamples SCL/SDA on clk, detects START/STOP,
//   ACKs SLAVE_ADDR, loads a sub-address into an auto-incrementing pointer,
//   strobes register writes and serves reads from a combinational read port.
//   clk, reset      : system clock (>= 16x SCL), synchronous active-high reset
//   bus             : I2C pins (i2c_slave_if.slave)
//   o_wr_en         : one-cycle register write strobe
//   o_wr_addr/data  : write address/data, held until the next strobe
//   o_rd_addr       : current register pointer (read port address)
//   i_rd_data       : register contents at o_rd_addr, combinational from user logic
//   o_busy          : high while in an acknowledged transfer
module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'h68
) (
   input  logic       clk,
   input  logic       reset,
   i2c_slave_if.slave bus,
   output logic       o_wr_en,
   output logic [7:0] o_wr_addr,
   output logic [7:0] o_wr_data,
   output logic [7:0] o_rd_addr,
   input  logic [7:0] i_rd_data,
   output logic       o_busy
);

   typedef enum logic [3:0] {
      ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_SUB, ST_SUB_ACK,
      ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_WAIT_STOP
   } state_t;

   state_t     r_state, w_next_state;

   logic       r_scl_s1, r_scl_s2, r_scl_h;
   logic       r_sda_s1, r_sda_s2, r_sda_h;
   logic [7:0] r_shift;
   logic [2:0] r_bitcnt;
   logic [7:0] r_ptr;
   logic       r_rw;
   logic       r_ack_ph;   // 0: waiting for fall that ends bit 8, 1: ACK driven
   logic       r_load;     // read byte must be fetched on the next SCL fall
   logic       r_sda_out, r_sda_oe;
   logic       r_wr_en;
   logic [7:0] r_wr_addr, r_wr_data;

   logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_last;
   logic [7:0] w_byte;

   // Two-stage synchronizer plus history stage; idle bus level is high
   always_ff @(posedge clk) begin
      if (reset) begin
         {r_scl_s1, r_scl_s2, r_scl_h} <= '1;
         {r_sda_s1, r_sda_s2, r_sda_h} <= '1;
      end else begin
         r_scl_s1 <= bus.scl_in;
         r_scl_s2 <= r_scl_s1;
         r_scl_h  <= r_scl_s2;
         r_sda_s1 <= bus.sda_in;
         r_sda_s2 <= r_sda_s1;
         r_sda_h  <= r_sda_s2;
      end
   end

   assign w_scl_rise = r_scl_s2 & ~r_scl_h;
   assign w_scl_fall = ~r_scl_s2 & r_scl_h;
   assign w_start    = ~r_sda_s2 & r_sda_h & r_scl_s2 & r_scl_h;
   assign w_stop     = r_sda_s2 & ~r_sda_h & r_scl_s2 & r_scl_h;
   assign w_byte     = {r_shift[6:0], r_sda_s2};
   assign w_last     = (r_bitcnt == 3'd0);

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state logic; START/STOP override bit processing in every state
   always_comb begin
      w_next_state = r_state;
      if (w_start) begin
         w_next_state = ST_ADDR;
      end else if (w_stop) begin
         w_next_state = ST_IDLE;
      end else begin
         case (r_state)
            ST_ADDR:
               if (w_scl_rise && w_last)
                  w_next_state = (w_byte[7:1] == SLAVE_ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
            ST_ADDR_ACK:
               if (w_scl_fall && r_ack_ph)
                  w_next_state = r_rw ? ST_RDATA : ST_SUB;
            ST_SUB:
               if (w_scl_rise && w_last) w_next_state = ST_SUB_ACK;
            ST_SUB_ACK:
               if (w_scl_fall && r_ack_ph) w_next_state = ST_WDATA;
            ST_WDATA:
               if (w_scl_rise && w_last) w_next_state = ST_WDATA_ACK;
            ST_WDATA_ACK:
               if (w_scl_fall && r_ack_ph) w_next_state = ST_WDATA;
            ST_RDATA:
               if (w_scl_fall && !r_load && w_last) w_next_state = ST_RDATA_ACK;
            ST_RDATA_ACK:
               if (w_scl_rise) w_next_state = r_sda_s2 ? ST_WAIT_STOP : ST_RDATA;
            default: ;
         endcase
      end
   end

   // Outputs
   always_comb begin
      bus.sda_out      = r_sda_out;
      bus.sda_out_mode = r_sda_oe;
      o_wr_en          = r_wr_en;
      o_wr_addr        = r_wr_addr;
      o_wr_data        = r_wr_data;
      o_rd_addr        = r_ptr;
      o_busy           = !(r_state inside {ST_IDLE, ST_ADDR, ST_WAIT_STOP});
   end

   // Datapath: shift register, bit counter, pointer, SDA drive, write strobe.
   // Read bytes are fetched on the SCL fall that starts them: directly when the
   // address ACK ends, or via r_load on the fall after a master ACK.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shift   <= '0;
         r_bitcnt  <= 3'd7;
         r_ptr     <= '0;
         r_rw      <= 1'b0;
         r_ack_ph  <= 1'b0;
         r_load    <= 1'b0;
         r_sda_out <= 1'b1;
         r_sda_oe  <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= 1'b0;
         if (w_start || w_stop) begin
            r_sda_oe  <= 1'b0;
            r_sda_out <= 1'b1;
            r_bitcnt  <= 3'd7;
            r_ack_ph  <= 1'b0;
            r_load    <= 1'b0;
         end else begin
            case (r_state)
               ST_ADDR, ST_SUB, ST_WDATA:
                  if (w_scl_rise) begin
                     r_shift  <= w_byte;
                     r_bitcnt <= r_bitcnt - 3'd1;
                     r_ack_ph <= 1'b0;
                     if (w_last) begin
                        if (r_state == ST_ADDR) r_rw <= w_byte[0];
                        if (r_state == ST_SUB)  r_ptr <= w_byte;
                        if (r_state == ST_WDATA) begin
                           r_wr_en   <= 1'b1;
                           r_wr_addr <= r_ptr;
                           r_wr_data <= w_byte;
                        end
                     end
                  end
               ST_ADDR_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
                  if (w_scl_fall) begin
                     if (!r_ack_ph) begin
                        r_sda_oe  <= 1'b1;
                        r_sda_out <= 1'b0;
                        r_ack_ph  <= 1'b1;
                     end else begin
                        r_ack_ph <= 1'b0;
                        r_bitcnt <= 3'd7;
                        if (r_state == ST_ADDR_ACK && r_rw) begin
                           r_shift   <= i_rd_data;
                           r_sda_out <= i_rd_data[7];
                           r_sda_oe  <= 1'b1;
                        end else begin
                           r_sda_oe  <= 1'b0;
                           r_sda_out <= 1'b1;
                        end
                     end
                  end
                  if (w_scl_rise && r_ack_ph && r_state == ST_WDATA_ACK)
                     r_ptr <= r_ptr + 8'd1;
               end
               ST_RDATA:
                  if (w_scl_fall) begin
                     if (r_load) begin
                        r_load    <= 1'b0;
                        r_shift   <= i_rd_data;
                        r_sda_out <= i_rd_data[7];
                        r_sda_oe  <= 1'b1;
                        r_bitcnt  <= 3'd7;
                     end else if (w_last) begin
                        r_sda_oe  <= 1'b0;
                        r_sda_out <= 1'b1;
                     end else begin
                        r_shift   <= {r_shift[6:0], 1'b0};
                        r_sda_out <= r_shift[6];
                        r_bitcnt  <= r_bitcnt - 3'd1;
                     end
                  end
               ST_RDATA_ACK:
                  if (w_scl_rise && !r_sda_s2) begin
                     r_ptr  <= r_ptr + 8'd1;
                     r_load <= 1'b1;
                  end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

Register-oriented I2C target: the receive/respond end of the I2C write transaction our master issues (7-bit address, sub-address byte, data bytes). It oversamples SCL/SDA on the fast system clock and detects START/STOP. It ACKs its own address, captures the sub-address into an auto-incrementing pointer, and emits one-cycle register-write strobes. It also serves reads from a user register file via a combinational read port.

## Interface
- SLAVE_ADDR, 7'h68, 7-bit address this target responds to
- clk  in  1  system clock; frequency ≥ 16× SCL
- reset  in  1  synchronous, active-high
- scl_in  in  1  bus SCL, asynchronous
- sda_in  in  1  bus SDA, asynchronous
- sda_out  out  1  SDA value while driving (0 for ACK, data bit for reads)
- sda_out_mode  out  1  1 = drive sda_out onto SDA, 0 = release (input)
- wr_en  out  1  one-cycle write strobe
- wr_addr  out  8  register address for wr_en
- wr_data  out  8  register data for wr_en
- rd_addr  out  8  current register pointer (read port address)
- rd_data  in  8  register contents at rd_addr, combinational from user logic
- busy  out  1  1 from address match until STOP/START/NACK release

## Operation
- Input conditioning: scl_in and sda_in each pass through a 2-FF synchronizer plus a 3rd history FF. Edges come from synchronized vs. history.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both are recognised in every state and take priority over bit processing.
- Bits are sampled on SCL rising edge. The slave changes SDA only on SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- IDLE: ignore the bus. START → ADDR with bit counter = 7.
- ADDR: shift 8 bits MSB-first (7 address bits + R/W).
  - Match with R/W=0 → ADDR_ACK → SUB.
  - Match with R/W=1 → ADDR_ACK → RDATA.
  - Mismatch → WAIT_STOP; SDA stays released and no ACK is driven.
- SUB: shift 8 bits, load the pointer (rd_addr), ACK → WDATA.
- WDATA: shift 8 bits. At the 8th rising edge, wr_en pulses with wr_addr=pointer and wr_data=byte. Then ACK, pointer+1 (8-bit wrap, 0xFF→0x00) → WDATA.
- RDATA: at SCL falling edge, latch rd_data into the shift register and drive the MSB. Subsequent falling edges drive the next bits. After the 8th bit, release SDA → RDATA_ACK.
- RDATA_ACK: sample SDA on the rising edge.
  - 0 (ACK): pointer+1 → RDATA.
  - 1 (NACK): → WAIT_STOP.
- WAIT_STOP: SDA released. STOP → IDLE; START → ADDR.
- Repeated START in any state → ADDR; the pointer is preserved.
- STOP in any state → IDLE, SDA released within 1 clk. A partial byte is discarded and there is no wr_en.
- busy = state not in {IDLE, ADDR, WAIT_STOP}.

## Timing
- Reset values: sda_out=1, sda_out_mode=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, state=IDLE.
- Reset asserted mid-transfer releases SDA on the next clk edge and returns to IDLE.
- Pin-to-detection latency: 3 clk (2 sync + 1 edge register).
- ACK window: sda_out_mode=1, sda_out=0 from the clk after detecting the SCL falling edge that ends bit 8 until the clk after detecting the SCL falling edge that ends bit 9.
- wr_en: high for exactly 1 clk, the clk after the 8th data-bit rising edge is detected. wr_addr and wr_data are valid in that cycle and hold until the next strobe.
- rd_data: sampled in the same clk the SCL falling edge that starts a read byte is detected. User logic must present it combinationally from rd_addr.
- The pointer increments 1 clk after the ACK (write) or master-ACK (read) rising edge is detected.
- SDA output changes ≤ 4 clk after SCL falls. This requires clk ≥ 16× SCL so output data is stable well before the next SCL rise.

## Test plan
- Write 0x68+W, sub 0x20, data 0x0F, STOP → ACK on all 3 bytes; exactly one wr_en with wr_addr=0x20, wr_data=0x0F; busy low after STOP.
- Address 0x50+W → no ACK (sda_out_mode=0 throughout), no wr_en, state WAIT_STOP until STOP.
- Write sub 0xFE, data 0xAA, 0xBB, 0xCC → wr_en at 0xFE/0xAA, 0xFF/0xBB, 0x00/0xCC (pointer wrap).
- Write sub 0x10, repeated START, 0x68+R, rd_data model returns addr^0x5A; master ACKs once then NACKs → bytes 0x4A, 0x4B on SDA MSB-first; then released; IDLE after STOP.
- STOP after 4 bits of a data byte → no wr_en; IDLE; a following full transaction works normally.
- Reset asserted during ADDR_ACK → sda_out_mode=0 next clk; all outputs at reset values; no ACK completion.
